// File: rtl/hilo_unit_if.sv
// EX-stage <-> HI/LO unit bundle: product issue, flush, MT writes, MF reads and status.
interface hilo_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [2*DATA_WIDTH-1:0] product;
  logic                    productValid;
  logic                    flush;
  logic                    mthi;
  logic                    mtlo;
  logic [DATA_WIDTH-1:0]   wrData;
  logic                    mfhi;
  logic                    mflo;
  logic [DATA_WIDTH-1:0]   rdData;
  logic [DATA_WIDTH-1:0]   hiOut;
  logic [DATA_WIDTH-1:0]   loOut;
  logic                    busy;
  logic                    stall;
  logic                    Z;
  logic                    S;

  modport master (
    output product, productValid, flush, mthi, mtlo, wrData, mfhi, mflo,
    input  rdData, hiOut, loOut, busy, stall, Z, S
  );

  modport slave (
    input  product, productValid, flush, mthi, mtlo, wrData, mfhi, mflo,
    output rdData, hiOut, loOut, busy, stall, Z, S
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register owner with an MULT_LATENCY-deep product pipeline and EX-stage interlock.
// Define HILO_FWD_EN to forward the retiring product to MFHI/MFLO instead of stalling them.
module hilo_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  hilo_unit_if.slave  bus
);
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int LAST = MULT_LATENCY - 1;

  logic [MULT_LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]           dat_q [MULT_LATENCY];
  logic [PW-1:0]           dat_d [MULT_LATENCY];
  logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                    z_q, z_d, s_q, s_d;

  logic                    busy, accept, retire, rd_req, wr_req, rd_stall, stall;
  logic [DATA_WIDTH-1:0]   rd_hi, rd_lo, rd_dat;

  always_comb begin
    busy   = |vld_q;
    accept = bus.productValid & ~busy & ~bus.flush;
    retire = vld_q[LAST] & ~bus.flush;
    rd_req = bus.mfhi | bus.mflo;
    wr_req = bus.productValid | bus.mthi | bus.mtlo;
`ifdef HILO_FWD_EN
    // The retiring product is already known, so reads can bypass the registers.
    rd_stall = rd_req & ~vld_q[LAST];
    rd_hi    = vld_q[LAST] ? dat_q[LAST][PW-1:DATA_WIDTH] : hi_q;
    rd_lo    = vld_q[LAST] ? dat_q[LAST][DATA_WIDTH-1:0]  : lo_q;
`else
    rd_stall = rd_req;
    rd_hi    = hi_q;
    rd_lo    = lo_q;
`endif
    // Uses pre-flush busy on purpose: a flush does not release this cycle's requests.
    stall  = busy & (wr_req | rd_stall);

    rd_dat = '0;
    if (!stall) begin
      if (bus.mfhi)      rd_dat = rd_hi;
      else if (bus.mflo) rd_dat = rd_lo;
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    dat_d[0] = accept ? bus.product : dat_q[0];
    for (int k = 1; k < MULT_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1] & ~bus.flush;
      dat_d[k] = dat_q[k-1];
    end
  end

  // MT writes only happen when idle and retire only when busy, so they never collide.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    z_d  = z_q;
    s_d  = s_q;
    if (!busy && bus.mthi) hi_d = bus.wrData;
    if (!busy && bus.mtlo) lo_d = bus.wrData;
    if (retire) begin
      hi_d = dat_q[LAST][PW-1:DATA_WIDTH];
      lo_d = dat_q[LAST][DATA_WIDTH-1:0];
      z_d  = ~|dat_q[LAST];
      s_d  = dat_q[LAST][PW-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < MULT_LATENCY; k++) dat_q[k] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      z_q   <= 1'b0;
      s_q   <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < MULT_LATENCY; k++) dat_q[k] <= dat_d[k];
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      z_q   <= z_d;
      s_q   <= s_d;
    end
  end

  assign bus.rdData = rd_dat;
  assign bus.hiOut  = hi_q;
  assign bus.loOut  = lo_q;
  assign bus.busy   = busy;
  assign bus.stall  = stall;
  assign bus.Z      = z_q;
  assign bus.S      = s_q;
endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: reset, retire timing, read interlock, flush, back-to-back, MT ordering, async reset.
module tb_hilo_unit;
  localparam int W = 32;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hilo_unit_if #(.DATA_WIDTH(W)) bus ();

  hilo_unit #(.DATA_WIDTH(W), .MULT_LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.product      = '0;
    bus.productValid = 1'b0;
    bus.flush        = 1'b0;
    bus.mthi         = 1'b0;
    bus.mtlo         = 1'b0;
    bus.wrData       = '0;
    bus.mfhi         = 1'b0;
    bus.mflo         = 1'b0;
  endtask

  // Start of a cycle: just after the rising edge. Samples are taken at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mid_cycle();
    check_eq("rst_hi",    bus.hiOut,  0);
    check_eq("rst_lo",    bus.loOut,  0);
    check_eq("rst_busy",  bus.busy,   0);
    check_eq("rst_stall", bus.stall,  0);
    check_eq("rst_rd",    bus.rdData, 0);
    check_eq("rst_z",     bus.Z,      0);
    check_eq("rst_s",     bus.S,      0);

    next_cycle();
    rst_n    = 1'b1;
    bus.mfhi = 1'b1;
    mid_cycle();
    check_eq("idle_mfhi_rd",    bus.rdData, 0);
    check_eq("idle_mfhi_stall", bus.stall,  0);

    // Basic retire with MFLO held from cycle 1.
    next_cycle();
    bus.mfhi         = 1'b0;
    bus.product      = 64'h0000_0001_8000_0000;
    bus.productValid = 1'b1;
    mid_cycle();
    check_eq("ret_c0_busy",  bus.busy,  0);
    check_eq("ret_c0_stall", bus.stall, 0);
    next_cycle();
    bus.productValid = 1'b0;
    bus.product      = '0;
    bus.mflo         = 1'b1;
    mid_cycle();
    check_eq("ret_c1_busy",  bus.busy,  1);
    check_eq("ret_c1_stall", bus.stall, 1);
    next_cycle();
    mid_cycle();
    check_eq("ret_c2_busy",  bus.busy,  1);
    check_eq("ret_c2_stall", bus.stall, 1);
    check_eq("ret_c2_lo",    bus.loOut, 0);
    next_cycle();
    mid_cycle();
    check_eq("ret_c3_busy", bus.busy,  1);
    check_eq("ret_c3_hi",   bus.hiOut, 0);
`ifdef HILO_FWD_EN
    check_eq("ret_c3_stall_fwd", bus.stall,  0);
    check_eq("ret_c3_rd_fwd",    bus.rdData, 32'h8000_0000);
`else
    check_eq("ret_c3_stall", bus.stall, 1);
`endif
    next_cycle();
    mid_cycle();
    check_eq("ret_c4_busy",  bus.busy,   0);
    check_eq("ret_c4_stall", bus.stall,  0);
    check_eq("ret_c4_rd",    bus.rdData, 32'h8000_0000);
    check_eq("ret_c4_hi",    bus.hiOut,  32'h1);
    check_eq("ret_c4_lo",    bus.loOut,  32'h8000_0000);
    check_eq("ret_c4_z",     bus.Z,      0);
    check_eq("ret_c4_s",     bus.S,      0);

    // Flush in the retire cycle suppresses the write.
    next_cycle();
    idle_inputs();
    bus.product      = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.productValid = 1'b1;
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    bus.flush = 1'b1;
    mid_cycle();
    check_eq("fl_c3_busy", bus.busy, 1);
    next_cycle();
    bus.flush = 1'b0;
    mid_cycle();
    check_eq("fl_c4_busy", bus.busy,  0);
    check_eq("fl_c4_hi",   bus.hiOut, 32'h1);
    check_eq("fl_c4_lo",   bus.loOut, 32'h8000_0000);
    check_eq("fl_c4_s",    bus.S,     0);
    check_eq("fl_c4_z",    bus.Z,     0);

    // Back-to-back issue of a zero product.
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      bus.product      = '0;
      bus.productValid = 1'b1;
      mid_cycle();
      check_eq($sformatf("b2b_c%0d_stall", c), bus.stall, (c >= 1 && c <= 3) ? 1 : 0);
    end
    check_eq("b2b_c4_busy", bus.busy,  0);
    check_eq("b2b_c4_z",    bus.Z,     1);
    check_eq("b2b_c4_hi",   bus.hiOut, 0);
    check_eq("b2b_c4_lo",   bus.loOut, 0);
    next_cycle();
    bus.productValid = 1'b0;
    mid_cycle();
    check_eq("b2b_c5_busy", bus.busy, 1);
    for (int c = 6; c <= 8; c++) next_cycle();
    mid_cycle();
    check_eq("b2b_c8_busy", bus.busy, 0);
    check_eq("b2b_c8_z",    bus.Z,    1);

    // MTHI issued together with MULT: MT lands first, product overwrites on retire.
    next_cycle();
    bus.mthi         = 1'b1;
    bus.wrData       = 32'hDEAD_BEEF;
    bus.productValid = 1'b1;
    bus.product      = 64'h0000_0002_0000_0003;
    mid_cycle();
    check_eq("mt_c0_stall", bus.stall, 0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 2) begin
        bus.mtlo   = 1'b1;
        bus.wrData = 32'h5555_5555;
      end
      mid_cycle();
      check_eq($sformatf("mt_c%0d_hi", c), bus.hiOut, 32'hDEAD_BEEF);
      if (c == 2) check_eq("mt_c2_stall", bus.stall, 1);
    end
    next_cycle();
    idle_inputs();
    bus.mfhi = 1'b1;
    bus.mflo = 1'b1;
    mid_cycle();
    check_eq("mt_c4_hi",    bus.hiOut,  32'h2);
    check_eq("mt_c4_lo",    bus.loOut,  32'h3);
    check_eq("mt_c4_z",     bus.Z,      0);
    check_eq("mt_c4_rdpri", bus.rdData, 32'h2);
    next_cycle();
    idle_inputs();
    bus.mtlo   = 1'b1;
    bus.wrData = 32'h0000_1234;
    next_cycle();
    idle_inputs();
    mid_cycle();
    check_eq("mtlo_lo", bus.loOut, 32'h0000_1234);
    check_eq("mtlo_hi", bus.hiOut, 32'h2);

    // Retire a negative product so S is set before the reset test.
    next_cycle();
    bus.productValid = 1'b1;
    bus.product      = 64'h8000_0000_0000_0000;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      idle_inputs();
    end
    mid_cycle();
    check_eq("neg_s",  bus.S,     1);
    check_eq("neg_z",  bus.Z,     0);
    check_eq("neg_hi", bus.hiOut, 32'h8000_0000);

    // Async reset in cycle 2 of an in-flight product.
    next_cycle();
    bus.productValid = 1'b1;
    bus.product      = 64'h0000_0005_0000_0007;
    next_cycle();
    idle_inputs();
    next_cycle();
    bus.mfhi = 1'b1;
    #1;
    check_eq("ar_pre_stall", bus.stall, 1);
    rst_n = 1'b0;
    #1;
    check_eq("ar_hi",    bus.hiOut,  0);
    check_eq("ar_lo",    bus.loOut,  0);
    check_eq("ar_busy",  bus.busy,   0);
    check_eq("ar_stall", bus.stall,  0);
    check_eq("ar_rd",    bus.rdData, 0);
    check_eq("ar_s",     bus.S,      0);
    check_eq("ar_z",     bus.Z,      0);
    bus.mfhi = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int c = 4; c <= 6; c++) next_cycle();
    mid_cycle();
    check_eq("ar_after_hi",   bus.hiOut, 0);
    check_eq("ar_after_lo",   bus.loOut, 0);
    check_eq("ar_after_busy", bus.busy,  0);
    check_eq("ar_after_z",    bus.Z,     0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
